div_unit: RTL

- Sequential signed 32-bit divider for the multicycle MIPS datapath, placed directly downstream of the control unit.
- Started by the control unit's DivCtrl strobe. Produces quotient (LO) and remainder (HI) for the MFLO/MFHI paths.
- Returns DivOut (done) and divZero (div_zero) to the control unit's DIV / DIV_0 states.
- Restoring algorithm on operand magnitudes, one quotient bit per cycle, with sign correction at the end.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Divider request/result bundle between the control unit (master) and div_unit (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Sequential signed divider (MIPS div): restoring on magnitudes, one quotient bit per cycle, sign fix at end.
// Result and done arrive WIDTH+1 edges after start is accepted; start is ignored while busy.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;

  // Remainder stays below mag, so WIDTH+1 bits hold the shifted value and the trial sign.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, mag_q};
  assign dvd_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_abs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            div_zero_d = 1'b1;
          end else begin
            quo_d     = dvd_abs;
            mag_d     = dvs_abs;
            rem_d     = '0;
            neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_rem_d = bus.dividend[WIDTH-1];
            cnt_d     = CW'(WIDTH);
            busy_d    = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
endmodule
